pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter SKID, default 1: 0 gives a single-entry stage; 1 gives a two-entry skid-buffered stage.
REQ-003 Parameter RESET_DATA, default 0: WIDTH-bit value loaded into storage on reset and on flush.
REQ-004 clk  in  1: sole clock; all state updates on the falling edge.
REQ-005 reset_n  in  1: reset, asynchronous, active-low.
REQ-006 in_valid  in  1: upstream offers in_data/in_nop this cycle.
REQ-007 in_ready  out  1: stage accepts upstream data at the next falling edge.
REQ-008 in_data  in  WIDTH: upstream payload (control and operand bundle).
REQ-009 in_nop  in  1: upstream marks this payload as a bubble.
REQ-010 flush  in  1: discard all held entries.
REQ-011 out_valid  out  1: out_data/out_nop hold a live entry.
REQ-012 out_ready  in  1: downstream consumes the head entry at the next falling edge.
REQ-013 out_data  out  WIDTH: head-entry payload, driven directly from a register.
REQ-014 out_nop  out  1: head entry is a bubble; 1 when empty.
REQ-015 occupancy  out  2: number of held entries, 0..2.

Function
REQ-016 Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready; both are sampled at the falling edge.
REQ-017 Ordering: entries leave in arrival order; none is lost or duplicated unless flush is asserted.
REQ-018 SKID=0: in_ready = !out_valid | out_ready (combinational); occupancy never exceeds 1.
REQ-019 SKID=0 simultaneous in/out transfer: replace the head in the same edge; out_valid stays 1.
REQ-020 SKID=1: in_ready = !(occupancy==2), driven from a register with no combinational path from out_ready.
REQ-021 SKID=1 FSM states and transitions:
- EMPTY: in -> ONE.
- ONE: in & !out -> TWO; out & !in -> EMPTY; in & out -> ONE, with the head replaced.
- TWO: out -> ONE, with the skid entry promoted to the head.
- TWO with an input transfer cannot occur, because in_ready=0.
REQ-022 Latency: one falling edge from input transfer to out_valid=1 when the stage is empty.
REQ-023 flush=1 overrides stall, in_valid and out_ready: at that edge all entries are invalidated, storage is set to RESET_DATA, out_nop=1, and occupancy=0.
REQ-024 in_valid asserted together with flush is dropped.
REQ-025 A bubble (in_nop=1) occupies an entry like any other payload; out_nop follows the head entry.
REQ-026 out_valid=0 implies out_data=RESET_DATA and out_nop=1.
REQ-027 Downstream holds out_valid entries stable while out_ready=0: out_data and out_nop do not change.

Reset
REQ-028 Asynchronous reset_n=0 immediately forces the following, regardless of clk:
- out_valid=0, out_nop=1, out_data=RESET_DATA, occupancy=0;
- SKID=1: FSM to EMPTY and in_ready=1.
REQ-029 Reset mid-operation discards all held entries; the first transfer is accepted at the first falling edge after reset_n rises.

Structure
REQ-030 Shared package pipe_pkg holds the FSM state encoding (EMPTY, ONE, TWO) and the occupancy width constant.
REQ-031 One sub-module, pipe_entry, holds a single entry (data, nop and valid), with load, clear-to-RESET_DATA and hold controls.
- SKID=1 instantiates two pipe_entry instances: head and skid.
- SKID=0 instantiates one.

Verification
REQ-032 Reset with SKID=1 and WIDTH=32: after reset_n=0 then 1, check out_valid=0, out_nop=1, out_data=0, in_ready=1, occupancy=0.
REQ-033 Back-to-back streaming: push 0x11, 0x22, 0x33 on consecutive edges with out_ready=1; expect out_data 0x11, 0x22, 0x33 one edge later each, occupancy=1 throughout.
REQ-034 Stall fill: with out_ready=0, push 0xA, 0xB; expect occupancy=2, in_ready=0, out_data=0xA held; after out_ready=1, expect 0xA then 0xB.
REQ-035 Flush during stall: with occupancy=2 and in_valid=1 (data 0xC), assert flush=1; next edge expect occupancy=0, out_valid=0, out_nop=1, and 0xC never appears.
REQ-036 Bubble pass-through: push in_nop=1, data=0; expect out_valid=1, out_nop=1 one edge later, followed by a normal entry with out_nop=0.
REQ-037 SKID=0 variant: with out_ready toggling 1,0,1 and in_valid=1, check that in_ready equals !out_valid|out_ready each cycle, no entry is lost, and occupancy is at most 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register and its entry cells.
// Holds the skid FSM state encoding and the occupancy count width.
// No logic; imported by the stage top.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_entry.sv
// Single pipeline entry: payload, bubble flag and valid bit.
// Latency: updates on the falling edge of clk; async reset to empty.
// Backpressure: none internally; clear wins over load, else holds.
module pipe_entry #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_nop,
  output logic [WIDTH-1:0] q_data,
  output logic             q_nop,
  output logic             q_valid
);

  // An empty entry always shows RESET_DATA with the bubble flag set.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_data  <= RESET_DATA;
      q_nop   <= 1'b1;
      q_valid <= 1'b0;
    end else if (clear) begin
      q_data  <= RESET_DATA;
      q_nop   <= 1'b1;
      q_valid <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_nop   <= d_nop;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register, single-entry (SKID=0) or two-entry skid (SKID=1).
// Latency: one falling edge from input transfer to out_valid when empty.
// Backpressure: SKID=0 in_ready = !out_valid|out_ready; SKID=1 in_ready is a flop (low when full).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_nop,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nop,
  output logic [OCC_W-1:0] occupancy
);

  if (SKID != 0) begin : g_skid

    state_t           state;
    state_t           state_nxt;
    logic             rdy_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             head_load;
    logic             head_clr;
    logic             skid_load;
    logic             skid_clr;
    logic             promote;
    logic [WIDTH-1:0] head_d_data;
    logic             head_d_nop;
    logic [WIDTH-1:0] skid_data;
    logic             skid_nop;
    logic             skid_valid;

    // Flush masks both transfers so nothing is accepted or consumed at that edge.
    assign in_xfer  = in_valid & rdy_q & ~flush;
    assign out_xfer = out_valid & out_ready & ~flush;
    assign in_ready = rdy_q;

    // The head is refilled from the skid entry when draining from full, else from upstream.
    assign head_d_data = promote ? skid_data : in_data;
    assign head_d_nop  = promote ? skid_nop  : in_nop;

    // The head is always valid whenever the skid entry is, so this counts 0..2.
    assign occupancy = {skid_valid, out_valid & ~skid_valid};

    // State register; in_ready is precomputed from the next state so it never
    // depends combinationally on out_ready.
    always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= EMPTY;
        rdy_q <= 1'b1;
      end else begin
        state <= state_nxt;
        rdy_q <= (state_nxt != TWO);
      end
    end

    // Next-state and entry load/clear decode.
    always_comb begin
      state_nxt = state;
      head_load = 1'b0;
      head_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      promote   = 1'b0;
      if (flush) begin
        state_nxt = EMPTY;
        head_clr  = 1'b1;
        skid_clr  = 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (in_xfer) begin
              head_load = 1'b1;
              state_nxt = ONE;
            end
          end
          ONE: begin
            if (in_xfer && !out_xfer) begin
              skid_load = 1'b1;
              state_nxt = TWO;
            end else if (!in_xfer && out_xfer) begin
              head_clr  = 1'b1;
              state_nxt = EMPTY;
            end else if (in_xfer && out_xfer) begin
              head_load = 1'b1;
            end
          end
          TWO: begin
            if (out_xfer) begin
              head_load = 1'b1;
              promote   = 1'b1;
              skid_clr  = 1'b1;
              state_nxt = ONE;
            end
          end
          default: begin
            state_nxt = EMPTY;
            head_clr  = 1'b1;
            skid_clr  = 1'b1;
          end
        endcase
      end
    end

    pipe_entry #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_head (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (head_load),
      .clear   (head_clr),
      .d_data  (head_d_data),
      .d_nop   (head_d_nop),
      .q_data  (out_data),
      .q_nop   (out_nop),
      .q_valid (out_valid)
    );

    pipe_entry #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (skid_load),
      .clear   (skid_clr),
      .d_data  (in_data),
      .d_nop   (in_nop),
      .q_data  (skid_data),
      .q_nop   (skid_nop),
      .q_valid (skid_valid)
    );

  end else begin : g_single

    logic in_xfer;
    logic out_xfer;
    logic ent_clr;

    // Ready when empty or when the head leaves at the same edge.
    assign in_ready  = ~out_valid | out_ready;
    assign in_xfer   = in_valid & in_ready & ~flush;
    assign out_xfer  = out_valid & out_ready & ~flush;
    // A simultaneous in/out transfer reloads the head instead of clearing it.
    assign ent_clr   = flush | (out_xfer & ~in_xfer);
    assign occupancy = {1'b0, out_valid};

    pipe_entry #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_head (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (in_xfer),
      .clear   (ent_clr),
      .d_data  (in_data),
      .d_nop   (in_nop),
      .q_data  (out_data),
      .q_nop   (out_nop),
      .q_valid (out_valid)
    );

  end

endmodule
